// File: rtl/iter_shifter.sv
// Multicycle 16-bit shift/rotate unit (ROL, SLL, SRA, SRL, ROR).
// Walks the amount down in 4-bit and 1-bit steps under a start/busy/done handshake.
module iter_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] dataIn,
  input  logic [3:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic        err
);

  localparam int unsigned Width    = 16;
  localparam int unsigned AmtWidth = 4;

  localparam logic [2:0] OpRol = 3'd0;
  localparam logic [2:0] OpSll = 3'd1;
  localparam logic [2:0] OpSra = 3'd2;
  localparam logic [2:0] OpSrl = 3'd3;
  localparam logic [2:0] OpRor = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [Width-1:0]      work;
  logic [2:0]            opReg;
  logic [AmtWidth-1:0]   remaining;

  logic                  bigStep;
  logic [Width-1:0]      stepped;
  logic [AmtWidth-1:0]   nextRemaining;

  // One step of the captured operation, by 4 or by 1 bit.
  function automatic logic [Width-1:0] stepFn(input logic [Width-1:0] w,
                                              input logic [2:0] o,
                                              input logic big);
    logic [Width-1:0] r;
    r = w;
    if (big) begin
      case (o)
        OpRol:   r = {w[11:0], w[15:12]};
        OpSll:   r = {w[11:0], 4'b0000};
        OpSra:   r = {{4{w[15]}}, w[15:4]};
        OpSrl:   r = {4'b0000, w[15:4]};
        OpRor:   r = {w[3:0], w[15:4]};
        default: r = w;
      endcase
    end else begin
      case (o)
        OpRol:   r = {w[14:0], w[15]};
        OpSll:   r = {w[14:0], 1'b0};
        OpSra:   r = {w[15], w[15:1]};
        OpSrl:   r = {1'b0, w[15:1]};
        OpRor:   r = {w[0], w[15:1]};
        default: r = w;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    bigStep       = (remaining >= AmtWidth'(4));
    stepped       = stepFn(work, opReg, bigStep);
    nextRemaining = remaining - (bigStep ? AmtWidth'(4) : AmtWidth'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      opReg     <= '0;
      remaining <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= dataIn;
            opReg     <= op;
            remaining <= amt;
            busy      <= 1'b1;
            // Nothing to iterate: finish immediately with the operand untouched.
            if (amt == '0 || op > OpRor) begin
              state <= DONE;
              out   <= dataIn;
              done  <= 1'b1;
              err   <= (op > OpRor);
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= stepped;
          remaining <= nextRemaining;
          if (nextRemaining == '0) begin
            state <= DONE;
            out   <= stepped;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed cases plus random ops
// against an arithmetic reference model.
module tb_iter_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] dataIn;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        err;

  int nChecks = 0;
  int nFails  = 0;

  iter_shifter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .dataIn (dataIn),
    .amt    (amt),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full single-shot result computed directly from the operation definition.
  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] d, input logic [3:0] a);
    logic [31:0] dbl;
    dbl = {d, d};
    case (o)
      3'd0:    return 16'((dbl << a) >> 16);
      3'd1:    return 16'(d << a);
      3'd2:    return 16'($signed(d) >>> a);
      3'd3:    return 16'(d >> a);
      3'd4:    return 16'(dbl >> a);
      default: return d;
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] o, input logic [3:0] a);
    if (a == 0 || o > 3'd4) return 1;
    return 1 + int'(a) / 4 + int'(a) % 4;
  endfunction

  // Issue one op, wait for done, check latency/result/err and the return to idle.
  task automatic runOp(input string tag, input logic [2:0] o, input logic [15:0] d, input logic [3:0] a);
    int cycles;
    @(negedge clk);
    start = 1'b1; op = o; dataIn = d; amt = a;
    @(posedge clk); #1;
    start = 1'b0; dataIn = 16'($urandom); amt = 4'($urandom); op = 3'($urandom);
    cycles = 1;
    while (done !== 1'b1 && cycles < 30) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_lat"}, 32'(cycles), 32'(expLatency(o, a)));
    check({tag, "_out"}, 32'(out), 32'(model(o, d, a)));
    check({tag, "_err"}, 32'(err), 32'(o > 3'd4));
    check({tag, "_busyDone"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_doneFall"}, 32'(done), 32'd0);
    check({tag, "_busyFall"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(out), 32'(model(o, d, a)));
  endtask

  initial begin
    int doneSeen;
    rst = 1'b1; start = 1'b0; op = '0; dataIn = '0; amt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b0;

    runOp("ror4", 3'd4, 16'h1234, 4'd4);
    runOp("sra15", 3'd2, 16'h8000, 4'd15);
    runOp("srl15", 3'd3, 16'h8000, 4'd15);
    runOp("sll7", 3'd1, 16'h00FF, 4'd7);
    runOp("rol4", 3'd0, 16'h1234, 4'd4);
    runOp("rol0", 3'd0, 16'h8001, 4'd0);
    runOp("illegal", 3'd5, 16'hABCD, 4'd9);
    runOp("illegal7", 3'd7, 16'h5A5A, 4'd3);

    // Start while busy: second request must be ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd3; dataIn = 16'hF000; amt = 4'd8;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; dataIn = 16'h0001; amt = 4'd1;
    @(posedge clk); #1;
    check("busyStart_n2", 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busyStart_done", 32'(done), 32'd1);
    check("busyStart_out", 32'(out), 32'h00F0);
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    check("busyStart_extraDone", 32'(doneSeen), 32'd0);
    check("busyStart_hold", 32'(out), 32'h00F0);
    check("busyStart_idle", 32'(busy), 32'd0);

    // Reset in the middle of a long SRA.
    @(negedge clk);
    start = 1'b1; op = 3'd2; dataIn = 16'h8000; amt = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midRst_out", 32'(out), 32'h0);
    check("midRst_busy", 32'(busy), 32'd0);
    check("midRst_done", 32'(done), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    check("midRst_noDone", 32'(doneSeen), 32'd0);
    runOp("postRstRor", 3'd4, 16'h0003, 4'd1);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'd0; dataIn = 16'hFFFF; amt = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rstPrio_busy", 32'(busy), 32'd0);
    check("rstPrio_out", 32'(out), 32'h0);

    for (int i = 0; i < 40; i++) begin
      runOp("rand", 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
